// File: rtl/sensor_frame_parser_pkg.sv
// Shared constants and state encoding for the sensor frame parser.
// Frames look like 'H' <digits> 'T' <digits> LF, ASCII, CR tolerated anywhere.
`timescale 1ns/1ps
package sensor_frame_parser_pkg;

    localparam logic [7:0] CH_H  = 8'h48;
    localparam logic [7:0] CH_T  = 8'h54;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    localparam int MAX_DIGITS_DEF  = 3;
    localparam int TIMEOUT_CYC_DEF = 10_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUM  = 2'd1,
        TEMP = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CH_0) && (b <= CH_9);
    endfunction

endpackage

// File: rtl/sensor_frame_parser_ascii_dec_accum.sv
// Decimal accumulator shared by the humidity and temperature fields.
// The digit count saturates one past the limit so overflow stays sticky until cleared.
`timescale 1ns/1ps
module ascii_dec_accum
    import sensor_frame_parser_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int DW         = $clog2(MAX_DIGITS + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [3:0]    digit,
    output logic [9:0]    val,
    output logic [DW-1:0] dcnt,
    output logic          overflow,
    output logic          range_ok
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DIGITS);

    logic [9:0]    r_val;
    logic [DW-1:0] r_dcnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_val  <= 10'd0;
            r_dcnt <= '0;
        end else if (clr) begin
            r_val  <= 10'd0;
            r_dcnt <= '0;
        end else if (en) begin
            r_val <= r_val * 10'd10 + {6'd0, digit};
            if (r_dcnt <= MAX_D) begin
                r_dcnt <= r_dcnt + DW'(1);
            end
        end
    end

    assign val      = r_val;
    assign dcnt     = r_dcnt;
    assign overflow = (r_dcnt > MAX_D);
    assign range_ok = (r_val <= 10'd255);

endmodule

// File: rtl/sensor_frame_parser.sv
// Parses 'H'nnn'T'nnn LF frames popped from a first-word-fall-through RX FIFO
// into binary humidity/temperature, with error and good-frame counters.
`timescale 1ns/1ps
module sensor_frame_parser
    import sensor_frame_parser_pkg::*;
#(
    parameter int MAX_DIGITS  = MAX_DIGITS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data,
    output logic        rx_pop,
    output logic [7:0]  humidity,
    output logic [7:0]  temperature,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int DW = $clog2(MAX_DIGITS + 2);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DIGITS);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_hum_tmp;
    logic [7:0]    r_humidity;
    logic [7:0]    r_temperature;
    logic          r_frame_valid;
    logic          r_frame_err;
    logic [15:0]   r_frame_cnt;
    logic [7:0]    r_err_cnt;

    logic          w_byte_ev;
    logic          w_is_digit;
    logic          w_is_h;
    logic          w_is_t;
    logic          w_is_lf;
    logic          w_in_frame;
    logic          w_timeout;
    logic          w_dig_full;
    logic          w_field_ok;
    logic [9:0]    w_val;
    logic [DW-1:0] w_dcnt;
    logic          w_overflow;
    logic          w_range_ok;
    logic          w_acc_clr;
    logic          w_acc_en;
    logic          w_ev_start;
    logic          w_ev_hum_done;
    logic          w_ev_commit;
    logic          w_ev_err;
    logic          w_unused_hi;

    assign rx_pop     = rst & ~rx_empty;
    assign w_byte_ev  = rx_pop && (rx_data != CH_CR);
    assign w_is_digit = is_digit(rx_data);
    assign w_is_h     = (rx_data == CH_H);
    assign w_is_t     = (rx_data == CH_T);
    assign w_is_lf    = (rx_data == CH_LF);
    assign w_in_frame = (r_state == HUM) || (r_state == TEMP);
    assign w_timeout  = w_in_frame && !w_byte_ev && (r_tcnt == TMAX);
    assign w_dig_full = (w_dcnt >= MAX_D);
    assign w_field_ok = (w_dcnt != '0) && !w_overflow && w_range_ok;
    assign w_unused_hi = ^w_val[9:8];

    ascii_dec_accum #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_acc_clr),
        .en       (w_acc_en),
        .digit    (rx_data[3:0]),
        .val      (w_val),
        .dcnt     (w_dcnt),
        .overflow (w_overflow),
        .range_ok (w_range_ok)
    );

    // Classify the popped byte; the FSM below only applies the resulting event.
    always_comb begin
        w_acc_clr     = 1'b0;
        w_acc_en      = 1'b0;
        w_ev_start    = 1'b0;
        w_ev_hum_done = 1'b0;
        w_ev_commit   = 1'b0;
        w_ev_err      = 1'b0;
        if (w_byte_ev) begin
            case (r_state)
                IDLE: begin
                    if (w_is_h) begin
                        w_ev_start = 1'b1;
                        w_acc_clr  = 1'b1;
                    end
                end
                HUM, TEMP: begin
                    if (w_is_digit && !w_dig_full) begin
                        w_acc_en = 1'b1;
                    end else begin
                        w_acc_clr = 1'b1;
                        if (w_is_digit) begin
                            w_ev_err = 1'b1;
                        end else if ((r_state == HUM) && w_is_t && w_field_ok) begin
                            w_ev_hum_done = 1'b1;
                        end else if ((r_state == TEMP) && w_is_lf && w_field_ok) begin
                            w_ev_commit = 1'b1;
                        end else begin
                            w_ev_err = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (w_timeout) begin
            w_ev_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_tcnt        <= '0;
            r_hum_tmp     <= 8'd0;
            r_humidity    <= 8'd0;
            r_temperature <= 8'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_err_cnt     <= 8'd0;
        end else begin
            r_frame_valid <= w_ev_commit;
            r_frame_err   <= w_ev_err;

            if (w_ev_err) begin
                // An 'H' mid-frame is taken as the start of a fresh frame.
                r_state <= (w_byte_ev && w_is_h) ? HUM : IDLE;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (w_ev_commit) begin
                r_state       <= IDLE;
                r_humidity    <= r_hum_tmp;
                r_temperature <= w_val[7:0];
                r_frame_cnt   <= r_frame_cnt + 16'd1;
            end else if (w_ev_hum_done) begin
                r_hum_tmp <= w_val[7:0];
                r_state   <= TEMP;
            end else if (w_ev_start) begin
                r_state <= HUM;
            end

            // CR counts as idle time, so it neither clears nor pauses the timeout.
            if (!w_in_frame || w_byte_ev || w_timeout) begin
                r_tcnt <= '0;
            end else begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign humidity    = r_humidity;
    assign temperature = r_temperature;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cnt   = r_frame_cnt;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_sensor_frame_parser.sv
// Directed bench for sensor_frame_parser: each task drives one scenario and checks inline.
`timescale 1ns/1ps
module tb_sensor_frame_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_pop;
    logic [7:0]  humidity;
    logic [7:0]  temperature;
    logic        frame_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;

    always #5 clk = ~clk;

    sensor_frame_parser #(
        .MAX_DIGITS  (3),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rx_pop      (rx_pop),
        .humidity    (humidity),
        .temperature (temperature),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
    end

    // Present each character for exactly one cycle with no gaps.
    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_empty = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_empty = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        rx_empty = 1'b1;
        idle(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx_empty = 1'b0;
        rx_data = 8'h48;
        @(posedge clk);
        #1;
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
        checks++; if (humidity !== 8'd0) begin errors++; $display("FAIL reset_humidity: got %0d want 0", humidity); end
        checks++; if (temperature !== 8'd0) begin errors++; $display("FAIL reset_temperature: got %0d want 0", temperature); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b err=%b want 0 0", frame_valid, frame_err); end
        rx_empty = 1'b1;
        rst = 1'b1;
        #1;
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL pop_when_empty: got %b want 0", rx_pop); end
        rx_empty = 1'b0;
        #1;
        checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL pop_when_ready: got %b want 1", rx_pop); end
        rx_empty = 1'b1;
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_good_frame();
        int bv;
        do_reset();
        bv = n_valid;
        push_str("H45T23\n");
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid_latency: got %b want 1", frame_valid); end
        checks++; if (humidity !== 8'h2D) begin errors++; $display("FAIL good_humidity: got %0d want 45", humidity); end
        checks++; if (temperature !== 8'h17) begin errors++; $display("FAIL good_temperature: got %0d want 23", temperature); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL good_frame_cnt: got %0d want 1", frame_cnt); end
        idle(1);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL good_valid_width: got %b want 0", frame_valid); end
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL good_valid_pulses: got %0d want 1", n_valid - bv); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
        $display("test_good_frame done: hum=%0d temp=%0d cnt=%0d", humidity, temperature, frame_cnt);
    endtask

    task automatic test_junk_cr();
        int be;
        int bv;
        do_reset();
        be = n_err;
        push_str("xyH060\r T7\r\n");
        idle(1);
        checks++; if (n_err - be !== 1) begin errors++; $display("FAIL junk_err_pulses: got %0d want 1", n_err - be); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL junk_err_cnt: got %0d want 1", err_cnt); end
        checks++; if (humidity !== 8'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL junk_unchanged: got hum=%0d cnt=%0d want 0 0", humidity, frame_cnt); end
        bv = n_valid;
        push_str("zzH060T7\r\n");
        checks++; if (humidity !== 8'd60) begin errors++; $display("FAIL cr_humidity: got %0d want 60", humidity); end
        checks++; if (temperature !== 8'd7) begin errors++; $display("FAIL cr_temperature: got %0d want 7", temperature); end
        idle(1);
        checks++; if (n_valid - bv !== 1) begin errors++; $display("FAIL cr_valid_pulses: got %0d want 1", n_valid - bv); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL cr_err_cnt: got %0d want 1", err_cnt); end
        $display("test_junk_cr done: hum=%0d temp=%0d errcnt=%0d", humidity, temperature, err_cnt);
    endtask

    task automatic test_range_errors();
        do_reset();
        push_str("H256");
        push_str("T");
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL range_256_err: got %b want 1", frame_err); end
        push_str("10\n");
        idle(1);
        checks++; if (humidity !== 8'd0 || frame_cnt !== 16'd0) begin errors++; $display("FAIL range_256_unchanged: got hum=%0d cnt=%0d want 0 0", humidity, frame_cnt); end
        push_str("H123");
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL digits_3_ok: got %b want 0", frame_err); end
        push_str("4");
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL digits_4_err: got %b want 1", frame_err); end
        push_str("T1\n");
        push_str("H");
        push_str("T");
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL empty_field_err: got %b want 1", frame_err); end
        push_str("5\n");
        idle(1);
        checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL range_err_cnt: got %0d want 3", err_cnt); end
        checks++; if (frame_cnt !== 16'd0 || humidity !== 8'd0) begin errors++; $display("FAIL range_no_commit: got cnt=%0d hum=%0d want 0 0", frame_cnt, humidity); end
        push_str("H255T000\n");
        checks++; if (frame_valid !== 1'b1 || humidity !== 8'd255 || temperature !== 8'd0) begin errors++; $display("FAIL boundary_255: got valid=%b hum=%0d temp=%0d want 1 255 0", frame_valid, humidity, temperature); end
        idle(1);
        checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL boundary_err_cnt: got %0d want 3", err_cnt); end
        $display("test_range_errors done: errcnt=%0d cnt=%0d", err_cnt, frame_cnt);
    endtask

    task automatic test_resync();
        int be;
        do_reset();
        be = n_err;
        push_str("H12H");
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL resync_err: got %b want 1", frame_err); end
        push_str("34T56\n");
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b want 1", frame_valid); end
        checks++; if (humidity !== 8'd34 || temperature !== 8'd56) begin errors++; $display("FAIL resync_values: got hum=%0d temp=%0d want 34 56", humidity, temperature); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL resync_frame_cnt: got %0d want 1", frame_cnt); end
        idle(1);
        checks++; if (n_err - be !== 1 || err_cnt !== 8'd1) begin errors++; $display("FAIL resync_err_count: got pulses=%0d cnt=%0d want 1 1", n_err - be, err_cnt); end
        $display("test_resync done: hum=%0d temp=%0d", humidity, temperature);
    endtask

    task automatic test_timeout();
        int k;
        bit found;
        do_reset();
        push_str("H12");
        k = 0;
        found = 1'b0;
        for (int c = 1; c <= 150 && !found; c++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                found = 1'b1;
                k = c;
            end
        end
        checks++; if (!found || k !== 100) begin errors++; $display("FAIL timeout_latency: got found=%0d cycles=%0d want 1 100", found, k); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_err_cnt: got %0d want 1", err_cnt); end
        push_str("T3\n");
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL timeout_no_commit: got %b want 0", frame_valid); end
        idle(1);
        checks++; if (frame_cnt !== 16'd0 || humidity !== 8'd0) begin errors++; $display("FAIL timeout_unchanged: got cnt=%0d hum=%0d want 0 0", frame_cnt, humidity); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL timeout_idle_ignore: got %0d want 1", err_cnt); end
        $display("test_timeout done: cycles=%0d errcnt=%0d", k, err_cnt);
    endtask

    task automatic test_back_to_back();
        int bv;
        do_reset();
        bv = n_valid;
        push_str("H10T20\nH30T40\nH50T60\n");
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_valid: got %b want 1", frame_valid); end
        checks++; if (humidity !== 8'd50 || temperature !== 8'd60) begin errors++; $display("FAIL b2b_values: got hum=%0d temp=%0d want 50 60", humidity, temperature); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want 3", frame_cnt); end
        idle(1);
        checks++; if (n_valid - bv !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", n_valid - bv); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL b2b_err_cnt: got %0d want 0", err_cnt); end
        $display("test_back_to_back done: cnt=%0d", frame_cnt);
    endtask

    task automatic test_reset_mid_frame();
        push_str("H77T8");
        rst = 1'b0;
        rx_empty = 1'b0;
        rx_data = 8'h48;
        @(posedge clk);
        #1;
        checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL midrst_pop: got %b want 0", rx_pop); end
        checks++; if (humidity !== 8'd0 || temperature !== 8'd0) begin errors++; $display("FAIL midrst_values: got hum=%0d temp=%0d want 0 0", humidity, temperature); end
        checks++; if (frame_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_counts: got cnt=%0d err=%0d want 0 0", frame_cnt, err_cnt); end
        rx_empty = 1'b1;
        rst = 1'b1;
        push_str("H9T99\n");
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid: got %b want 1", frame_valid); end
        checks++; if (humidity !== 8'd9 || temperature !== 8'd99) begin errors++; $display("FAIL midrst_next_frame: got hum=%0d temp=%0d want 9 99", humidity, temperature); end
        checks++; if (frame_cnt !== 16'd1 || err_cnt !== 8'd0) begin errors++; $display("FAIL midrst_next_counts: got cnt=%0d err=%0d want 1 0", frame_cnt, err_cnt); end
        idle(1);
        $display("test_reset_mid_frame done: hum=%0d temp=%0d", humidity, temperature);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_junk_cr();
        test_range_errors();
        test_resync();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles want 0", n_both); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
